// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle divider: state encoding, control levels
// and the ALU opcodes that select DIV/DIVU in the execute stage.
package div_unit_pkg;

    // Divider sequencing states (2-bit encoding)
    typedef enum logic [1:0] {
        DivIdle   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Control levels used by the execute stage when driving/consuming the divider
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // ALU operation codes routed to the divider
    localparam logic [7:0] AluOpDiv  = 8'b0001_1010;
    localparam logic [7:0] AluOpDivu = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle. Quotient goes to LO,
// remainder to HI. busy_o stalls the pipeline while an operation is in flight;
// annul_i drops it on a flush.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              ready_o,
    output logic              busy_o
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    div_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // rem_q:quo_q form the shifting {partial remainder, dividend/quotient} pair
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              ready_q, ready_d;

    logic              signed_mode;
    logic              dvd_neg, dvs_neg;
    logic [DATA_W-1:0] dvd_mag, dvs_mag;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] trial;
    logic              take;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    // Operand magnitudes/signs at acceptance, trial subtraction and end-of-run fix-up
    always_comb begin
        signed_mode = SIGNED_EN && signed_i;
        dvd_neg     = signed_mode && dividend_i[DATA_W-1];
        dvs_neg     = signed_mode && divisor_i[DATA_W-1];
        // Most-negative maps to 2^(DATA_W-1), which still fits unsigned
        dvd_mag     = dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
        dvs_mag     = dvs_neg ? (~divisor_i + 1'b1) : divisor_i;

        shifted     = {rem_q, quo_q[DATA_W-1]};
        // Extra top bit is the borrow: set means the trial went negative
        trial       = {1'b0, shifted} - {2'b00, dvs_q};
        take        = ~trial[DATA_W+1];

        quo_fix     = qneg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix     = rneg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = DivResultNotReady;

        unique case (state_q)
            DivIdle: begin
                if (start_i == DivStart && !annul_i) begin
                    cnt_d = '0;
                    if (divisor_i == '0) begin
                        // Divide-by-zero result is staged now; no fix-up applies
                        state_d = DivByZero;
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dvs_d   = '0;
                        qneg_d  = 1'b0;
                        rneg_d  = 1'b0;
                    end else begin
                        state_d = DivOn;
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        dvs_d   = dvs_mag;
                        qneg_d  = dvd_neg ^ dvs_neg;
                        rneg_d  = dvd_neg;
                    end
                end
            end
            DivByZero: begin
                state_d = annul_i ? DivIdle : DivEnd;
            end
            DivOn: begin
                if (annul_i) begin
                    state_d = DivIdle;
                end else begin
                    rem_d = take ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], take};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        state_d = DivEnd;
                    end
                end
            end
            DivEnd: begin
                state_d = DivIdle;
                if (!annul_i) begin
                    quotient_d  = quo_fix;
                    remainder_d = rem_fix;
                    ready_d     = DivResultReady;
                end
            end
            default: state_d = DivIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DivIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
        end
    end

    // Outputs: busy straight from state, results and ready from registers
    always_comb begin
        busy_o      = (state_q != DivIdle);
        quotient_o  = quotient_q;
        remainder_o = remainder_q;
        ready_o     = ready_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (DATA_W=32): directed cases plus randomized
// divisions compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        ready_o;
    logic        busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    div_unit #(
        .DATA_W    (32),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .annul_i     (annul_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SV signed division truncates toward zero
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Launch one division, return results, cycles from accepting edge to ready, busy cycles
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           input bit repulse, output logic [31:0] q, output logic [31:0] r,
                           output int lat, output int busy_cnt);
        @(negedge clk);
        dividend_i = a;
        divisor_i  = b;
        signed_i   = s;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i  = 1'b0;
        lat      = 0;
        busy_cnt = busy_o ? 1 : 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (repulse && i == 5) start_i = 1'b1;
            if (repulse && i == 6) start_i = 1'b0;
            if (ready_o) begin
                lat = i;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        q = quotient_o;
        r = remainder_o;
    endtask

    task automatic check_pulse_drop(input string tag);
        @(posedge clk);
        #1;
        check(tag, {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] q, r, eq, er, a, b;
        int          lat, bc;
        bit          s, seen;

        // Reset state while rst is held low
        #2;
        check("rst_quot", quotient_o, 32'd0);
        check("rst_rem", remainder_o, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Start together with annul is not accepted
        @(negedge clk);
        dividend_i = 32'd10;
        divisor_i  = 32'd2;
        start_i    = 1'b1;
        annul_i    = 1'b1;
        @(posedge clk);
        #1;
        check("annul_blocks_start", {31'd0, busy_o}, 32'd0);
        start_i = 1'b0;
        annul_i = 1'b0;

        // Unsigned 100/7
        run_div(32'd100, 32'd7, 1'b0, 1'b0, q, r, lat, bc);
        check("u100_7_q", q, 32'd14);
        check("u100_7_r", r, 32'd2);
        check("u100_7_lat", lat, 33);
        check("u100_7_busy", bc, 33);
        check_pulse_drop("u100_7_pulse");

        // Annul mid-run: no pulse, outputs hold 14/2
        @(negedge clk);
        dividend_i = 32'd50;
        divisor_i  = 32'd3;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        check("annul_busy", {31'd0, busy_o}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {31'd0, seen}, 32'd0);
        check("annul_hold_q", quotient_o, 32'd14);
        check("annul_hold_r", remainder_o, 32'd2);

        // Signed -7/2 and the same operands unsigned
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, q, r, lat, bc);
        check("s_m7_2_q", q, 32'hFFFF_FFFD);
        check("s_m7_2_r", r, 32'hFFFF_FFFF);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, q, r, lat, bc);
        check("u_m7_2_q", q, 32'h7FFF_FFFC);
        check("u_m7_2_r", r, 32'd1);

        // Divide by zero in both modes
        run_div(32'd5, 32'd0, 1'b0, 1'b0, q, r, lat, bc);
        check("u5_0_q", q, 32'hFFFF_FFFF);
        check("u5_0_r", r, 32'd5);
        check("u5_0_lat", lat, 2);
        check_pulse_drop("u5_0_pulse");
        run_div(32'd5, 32'd0, 1'b1, 1'b0, q, r, lat, bc);
        check("s5_0_q", q, 32'hFFFF_FFFF);
        check("s5_0_r", r, 32'd5);
        check("s5_0_lat", lat, 2);

        // Signed overflow and unsigned equivalent
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, q, r, lat, bc);
        check("s_ovf_q", q, 32'h8000_0000);
        check("s_ovf_r", r, 32'd0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, q, r, lat, bc);
        check("u_ovf_q", q, 32'd0);
        check("u_ovf_r", r, 32'h8000_0000);

        // Start re-pulsed while running is ignored
        run_div(32'd1000, 32'd9, 1'b0, 1'b1, q, r, lat, bc);
        check("repulse_q", q, 32'd111);
        check("repulse_r", r, 32'd1);
        check("repulse_lat", lat, 33);
        @(posedge clk);
        #1;
        check("repulse_idle", {31'd0, busy_o}, 32'd0);

        // Asynchronous reset between edges mid-run
        @(negedge clk);
        dividend_i = 32'd123;
        divisor_i  = 32'd4;
        signed_i   = 1'b0;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_quot", quotient_o, 32'd0);
        check("arst_rem", remainder_o, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_div(32'd9, 32'd3, 1'b0, 1'b0, q, r, lat, bc);
        check("post_rst_q", q, 32'd3);
        check("post_rst_r", r, 32'd0);

        // Randomized divisions against the reference model
        for (int k = 0; k < 24; k++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            ref_div(a, b, s, eq, er);
            run_div(a, b, s, 1'b0, q, r, lat, bc);
            check($sformatf("rnd%0d_q a=%h b=%h s=%0d", k, a, b, s), q, eq);
            check($sformatf("rnd%0d_r", k), r, er);
            check($sformatf("rnd%0d_lat", k), lat, (b == 32'd0) ? 2 : 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the execute stage. Implements DIV/DIVU and writes results into the hilo path: quotient to LO, remainder to HI.
- Runs one quotient bit per cycle. While a division is in flight, busy_o acts as the stall request to the pipeline control.
- Supports signed and unsigned mode, width generalisation, divide-by-zero handling and annul (flush) of an in-flight operation.

Parameters:
- DATA_W, 32, operand/result width in bits (>=4).
- SIGNED_EN, 1, 1 = honour signed_i; 0 = signed_i ignored, all divisions unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  request a division; sampled only in IDLE.
- signed_i  in  1  1 = two's-complement division.
- annul_i  in  1  cancel any in-flight division (pipeline flush).
- dividend_i  in  DATA_W  dividend, captured when start is accepted.
- divisor_i  in  DATA_W  divisor, captured when start is accepted.
- quotient_o  out  DATA_W  quotient (to LO).
- remainder_o  out  DATA_W  remainder (to HI).
- ready_o  out  1  one-cycle pulse; results valid and held from this cycle.
- busy_o  out  1  state != IDLE (stall request).

Behaviour:
- Reset:
  - rst low forces IDLE immediately, independent of clk.
  - quotient_o=0, remainder_o=0, ready_o=0, busy_o=0, iteration counter=0.
  - Reset mid-operation discards the operation.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 is accepted. The block latches operand magnitudes and the signs (sign-aware only if signed mode is active).
  - Divisor==0 goes to BY_ZERO; otherwise goes to ON with counter=0.
  - start_i while annul_i=1 is not accepted.
- ON:
  - Each cycle shifts the {partial remainder, dividend} register left by 1.
  - Trial-subtracts the divisor magnitude using DATA_W+1-bit arithmetic. On non-negative result, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - Counter increments; after DATA_W iterations go to END.
- BY_ZERO: one cycle, then END with quotient = all ones and remainder = dividend_i as captured (no sign fix-up).
- END:
  - Sign fix-up, in signed mode: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Registers quotient_o/remainder_o, asserts ready_o for exactly this one cycle, then returns to IDLE.
- Latency (ready_o pulse relative to the accepting edge):
  - Normal division: DATA_W+1 cycles (33 for DATA_W=32).
  - Divide by zero: 2 cycles.
- A new start may be accepted on the cycle after END.
- Results: quotient_o/remainder_o change only on END. They hold otherwise, including across annul and idle periods.
- start_i while busy: ignored, no queuing. The pipeline is stalled by busy_o and must re-present the request.
- annul_i=1 in BY_ZERO/ON/END:
  - Next state is IDLE and ready_o stays 0.
  - Outputs keep their previous values.
  - annul_i in END suppresses the pulse and the result update.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder = 0, with no trap. This falls out of the magnitude algorithm plus fix-up.
- Magnitude of most-negative is taken as unsigned 2^(DATA_W-1). The magnitude datapath is DATA_W bits unsigned, so no overflow occurs.
- busy_o is combinational from state: high from the cycle after acceptance through END inclusive.

Decomposition:
- Add to define.vh:
  - state encodings DivIdle, DivByZero, DivOn, DivEnd (2-bit).
  - DivStart/DivStop and DivResultReady/DivResultNotReady levels.
  - AluOp codes for DIV/DIVU.
- Single module, no sub-module. The magnitude/negate logic is small enough to stay inline.
- Top-level integration:
  - ex drives start_i/signed_i/operands.
  - ex forwards ready_o results into the hilo whilo path.
  - busy_o feeds the stall controller; the flush signal drives annul_i.

Test Plan (DATA_W=32):
- Unsigned 100/7 (signed_i=0) -> quotient 14, remainder 2; ready_o pulses exactly 33 cycles after the accepting edge; busy_o high for 33 cycles.
- Signed -7/2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Same operands with signed_i=0 -> quotient 0x7FFFFFFC, remainder 1.
- 5/0, either mode -> ready_o 2 cycles after the accepting edge; quotient 0xFFFFFFFF, remainder 5.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned same operands -> quotient 0, remainder 0x80000000.
- Annul and ignored start:
  - Complete 100/7, then start 50/3 and assert annul_i on cycle 10 -> IDLE next cycle, ready_o never pulses, outputs remain 14/2.
  - start_i re-pulsed during ON -> ignored, latency unchanged.
- Async reset: drop rst mid-ON, between clock edges -> outputs 0 and busy_o 0 without a clock edge. After release, a fresh 9/3 yields quotient 3, remainder 0.
